// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the serial Booth multiplier, its operand loader and
// the product accumulator.
//   DATA_W  : width of the multiplier's serial data word
//   PROD_W  : width of the full signed product (two data words)
//   CNT_W   : width of the accumulator's term counter
//   state_e : accumulator FSM states
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam int DATA_W = 5;
    localparam int PROD_W = 10;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAP_HI = 2'd1,
        ADD    = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/booth_product_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational signed saturating adder: ACC_W accumulator plus a sign-
// extended PROD_W product, clamped back into ACC_W bits.
//   i_acc   : current accumulator value (signed)
//   i_prod  : product to add (signed, PROD_W bits)
//   o_sum   : clamped sum
//   o_ovf   : high when the sum was clamped
// ---------------------------------------------------------------------------
module sat_add #(
    parameter int ACC_W  = 12,
    parameter int PROD_W = 10
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W:0]   w_acc_ext;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_max;
    logic [ACC_W-1:0] w_min;

    assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
    assign w_prod_ext = {{(ACC_W+1-PROD_W){i_prod[PROD_W-1]}}, i_prod};
    assign w_sum      = w_acc_ext + w_prod_ext;
    assign w_max      = {1'b0, {(ACC_W-1){1'b1}}};
    assign w_min      = {1'b1, {(ACC_W-1){1'b0}}};

    // One extra bit is enough headroom: the two top bits disagree exactly
    // when the true sum lies outside the ACC_W range.
    assign o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        o_sum = w_sum[ACC_W-1:0];
        if (o_ovf) begin
            o_sum = w_sum[ACC_W] ? w_min : w_max;
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// ---------------------------------------------------------------------------
// booth_product_accumulator
// Captures 10-bit signed products from the serial Booth multiplier (low word
// in the done cycle, high word the cycle after), accumulates N_TERMS of them
// with saturation and presents the sum on a valid/ready port.
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-low reset
//   i_mul_data  : multiplier data word
//   i_mul_done  : multiplier done pulse
//   i_clr       : synchronous clear of the accumulation in progress
//   i_out_ready : consumer accepts the result
//   o_acc_out   : accumulated signed sum, valid while o_acc_valid
//   o_acc_valid : result available
//   o_sat       : sticky saturation flag for the current result
//   o_drop      : sticky flag, a product arrived while busy and was lost
// ---------------------------------------------------------------------------
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_mul_data,
    input  logic              i_mul_done,
    input  logic              i_clr,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_acc_out,
    output logic              o_acc_valid,
    output logic              o_sat,
    output logic              o_drop
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [DATA_W-1:0]  r_lo;
    logic [DATA_W-1:0]  r_hi;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sat;
    logic               r_drop;

    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_last;

    assign w_prod    = {r_hi, r_lo};
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_inc == CNT_W'(N_TERMS));

    sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .i_acc  (r_acc),
        .i_prod (w_prod),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_mul_done) w_state_nxt = CAP_HI;
            CAP_HI:  w_state_nxt = ADD;
            ADD:     w_state_nxt = w_last ? HOLD : IDLE;
            HOLD:    if (i_out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_clr) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_drop <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mul_done) r_lo <= i_mul_data;
                end
                CAP_HI: begin
                    r_hi <= i_mul_data;
                    if (i_mul_done) r_drop <= 1'b1;
                end
                ADD: begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc;
                    if (w_ovf)      r_sat  <= 1'b1;
                    if (i_mul_done) r_drop <= 1'b1;
                end
                HOLD: begin
                    // A completed handshake starts a fresh result, so it
                    // wins over a product dropped in the same cycle.
                    if (i_out_ready) begin
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_sat  <= 1'b0;
                        r_drop <= 1'b0;
                    end else if (i_mul_done) begin
                        r_drop <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_acc_out   = r_acc;
    assign o_acc_valid = (r_state == HOLD);
    assign o_sat       = r_sat;
    assign o_drop      = r_drop;

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream consumer of the serial Booth multiplier. It captures each 10-bit signed product, which arrives as two 5-bit words on the multiplier's data output after `done`, and sign-extends it. It accumulates the product into a saturating signed accumulator. After `N_TERMS` products it presents the sum on a valid/ready output port, making a multiply-accumulate path out of the existing multiplier.

## Interface
- `ACC_W`, 12: accumulator and result width in bits, ≥ 10
- `N_TERMS`, 4: number of products summed per result, 1..255

- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-low reset
- `mul_data`  in  5  multiplier data output
- `mul_done`  in  1  multiplier done pulse, one cycle
- `clr`  in  1  synchronous clear of the accumulation in progress
- `out_ready`  in  1  consumer accepts the result
- `acc_out`  out  ACC_W  accumulated signed sum; valid while `acc_valid`
- `acc_valid`  out  1  result available
- `sat`  out  1  sticky: saturation occurred in the current result
- `drop`  out  1  sticky: a product was lost because the block was busy

## Operation
- Product framing:
  - In the `mul_done` cycle, `mul_data` = product[4:0].
  - In the next cycle, `mul_data` = product[9:5].
  - The product is 10-bit two's complement.
- States:
  - IDLE
  - CAP_HI
  - ADD
  - HOLD
- IDLE:
  - `mul_done`=1 → latch lo word, go to CAP_HI.
- CAP_HI:
  - Latch hi word unconditionally, go to ADD.
- ADD:
  - acc ← sat(acc + sext(prod)); cnt ← cnt+1.
  - If the new cnt == `N_TERMS` → HOLD, else → IDLE.
- HOLD:
  - `acc_valid`=1, `acc_out`=acc, both held stable.
  - `out_ready`=1 → handshake completes: acc, cnt, `sat` and `drop` all cleared, go to IDLE.
- Saturating add:
  - Computed at ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1 or is below -2^(ACC_W-1), clamp to that bound and set `sat`.
  - Clamping is per addition; later additions continue from the clamped value.
- `mul_done` in CAP_HI, ADD or HOLD: ignored, `drop` set. The multiplier cannot be stalled.
- `clr`=1 (lower priority only than `rst`):
  - acc, cnt, `sat` and `drop` cleared; state → IDLE; `acc_valid` → 0.
  - A `mul_done` in the same cycle is ignored.
- `rst`=0 (sampled on the clock edge):
  - Same effect as `clr`.
  - Reset values: `acc_out`=0, `acc_valid`=0, `sat`=0, `drop`=0.
  - Applies mid-capture and mid-HOLD; a partial product is discarded.

## Timing
- `mul_done` sampled at edge t → lo word latched at t; hi word latched at t+1; acc updated at t+2.
- When the product is the `N_TERMS`-th, `acc_valid` is high from after edge t+2.
- Minimum spacing between accepted `mul_done` pulses: 3 cycles, provided the block is not in HOLD.
- `acc_valid` rises at most once per `N_TERMS` products and never drops without a handshake, `clr` or `rst`.
- `out_ready` is ignored outside HOLD.
- Handshake edge → next state is IDLE; a `mul_done` one cycle later is accepted.
- `acc_out` is a registered output; no combinational path from inputs to outputs.

## Structure
- Package `booth_pkg`:
  - `DATA_W`=5 and `PROD_W`=10.
  - State enum: IDLE, CAP_HI, ADD, HOLD.
  - Shared with the multiplier and its operand loader.
- Sub-module `sat_add`: parameterized signed saturating adder, ACC_W + sext(PROD_W) → ACC_W plus overflow flag. Combinational; instantiated once.
- Top level holds:
  - FSM
  - lo/hi capture registers
  - 8-bit term counter
  - acc register and sticky flags

## Test plan
- Single product, `N_TERMS`=1:
  - Stimulus: `mul_done` with lo=5'b11001, then hi=5'b11011 (-15×9 = -135).
  - Response: `acc_valid` at t+2, `acc_out`=-135 (12'hF79), `sat`=0.
- Four products, default parameters:
  - Stimulus: products 6, -3, 100, -200.
  - Response: `acc_out`=-97; `acc_valid` only after the 4th product; held until `out_ready`, then acc=0.
- Saturation, `N_TERMS`=8, `ACC_W`=12:
  - Stimulus: eight products of 256 (lo=5'b00000, hi=5'b01000).
  - Response: `acc_out`=2047, `sat`=1.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 while in HOLD, send a `mul_done`.
  - Response: `drop`=1, `acc_out` unchanged; after handshake, `drop`=0 and the next product is accumulated from 0.
- Reset mid-capture:
  - Stimulus: `rst`=0 on the CAP_HI edge.
  - Response: all outputs 0, state IDLE; the next full product sums from 0.
- `clr` coincident with `mul_done` in IDLE:
  - Response: product ignored, cnt=0, no `drop`.
